// File: rtl/ps2_keyboard_fsm.sv
// PS/2 keyboard receiver: deserializes 11-bit frames and tracks make/break sequences.
// Optional E0 extended-key tracking is enabled with `define PS2_EXT_EN.
module ps2_keyboard_fsm #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 2000
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic             byte_valid,
    output logic [7:0]       byte_data,
    output logic             frame_err,
    output logic [7:0]       scan_code,
    output logic             key_down,
    output logic             key_ext,
    output logic [CNT_W-1:0] press_cnt
);

    localparam int unsigned TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [7:0]  BYTE_EXT = 8'hE0;
    localparam logic [7:0]  BYTE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_BREAK
    } state_t;

    logic [2:0]      ps2_sync;
    logic            ps2_fall;
    logic [3:0]      bit_cnt;
    logic [9:0]      shift;
    logic [TO_W-1:0] idle_cnt;
    logic            good_frame;

    state_t           state, state_nxt;
    logic [7:0]       scan_nxt;
    logic             down_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             scan_load;
    logic             key_match;
    logic             key_byte;

    // ps2_clk synchronizer; a falling edge shows up as flop2=0, flop3=1
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) ps2_sync <= 3'b111;
        else       ps2_sync <= {ps2_sync[1:0], ps2_clk};
    end

    assign ps2_fall = !ps2_sync[1] && ps2_sync[2];

    // shift holds start at [0], data at [8:1], parity at [9]; stop is the live bit
    assign good_frame = !shift[0] && ps2_data && (^shift[9:1]);

    // Deserializer with idle timeout that silently drops partial frames
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt    <= 4'd0;
            shift      <= 10'd0;
            idle_cnt   <= TO_W'(0);
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (ps2_fall) begin
                idle_cnt <= TO_W'(0);
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (good_frame) begin
                        byte_valid <= 1'b1;
                        byte_data  <= shift[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shift   <= {ps2_data, shift[9:1]};
                end
            end else if (bit_cnt != 4'd0) begin
                if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
                    bit_cnt  <= 4'd0;
                    idle_cnt <= TO_W'(0);
                end else begin
                    idle_cnt <= idle_cnt + TO_W'(1);
                end
            end else begin
                idle_cnt <= TO_W'(0);
            end
        end
    end

    // E0 prefixes never reach the key FSM directly
    assign key_byte = byte_valid && (byte_data != BYTE_EXT);

`ifdef PS2_EXT_EN
    logic ext_pending, pend_nxt, ext_nxt;

    assign key_match = (byte_data == scan_code) && (ext_pending == key_ext);

    // Prefix tracking: E0 arms, any real key byte disarms, F0 leaves it alone
    always_comb begin
        pend_nxt = ext_pending;
        ext_nxt  = key_ext;
        if (byte_valid) begin
            if (byte_data == BYTE_EXT)      pend_nxt = 1'b1;
            else if (byte_data != BYTE_BRK) pend_nxt = 1'b0;
        end
        if (scan_load) ext_nxt = ext_pending;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ext_pending <= 1'b0;
            key_ext     <= 1'b0;
        end else begin
            ext_pending <= pend_nxt;
            key_ext     <= ext_nxt;
        end
    end
`else
    assign key_match = (byte_data == scan_code);
    assign key_ext   = 1'b0;
`endif

    // Key FSM state and registered key outputs
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= ST_IDLE;
            scan_code <= 8'd0;
            key_down  <= 1'b0;
            press_cnt <= CNT_W'(0);
        end else begin
            state     <= state_nxt;
            scan_code <= scan_nxt;
            key_down  <= down_nxt;
            press_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        down_nxt  = key_down;
        cnt_nxt   = press_cnt;
        scan_load = 1'b0;
        if (key_byte) begin
            unique case (state)
                ST_IDLE: begin
                    if (byte_data == BYTE_BRK) begin
                        state_nxt = ST_BREAK;
                    end else begin
                        scan_load = 1'b1;
                        down_nxt  = 1'b1;
                        cnt_nxt   = press_cnt + CNT_W'(1);
                        state_nxt = ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (byte_data == BYTE_BRK) begin
                        state_nxt = ST_BREAK;
                    end else if (!key_match) begin
                        scan_load = 1'b1;
                        cnt_nxt   = press_cnt + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (key_match) begin
                        down_nxt  = 1'b0;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = key_down ? ST_PRESSED : ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        scan_nxt = scan_load ? byte_data : scan_code;
    end

endmodule

// File: tb/tb_ps2_keyboard_fsm.sv
// Directed bench for ps2_keyboard_fsm: table-driven frames plus timeout, reset, E0 and wrap sequences.
module tb_ps2_keyboard_fsm;

    localparam int unsigned CNT_W   = 2;
    localparam int unsigned TIMEOUT = 2000;

    logic             clk;
    logic             clrn;
    logic             ps2_clk;
    logic             ps2_data;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             frame_err;
    logic [7:0]       scan_code;
    logic             key_down;
    logic             key_ext;
    logic [CNT_W-1:0] press_cnt;

    ps2_keyboard_fsm #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err),
        .scan_code (scan_code),
        .key_down  (key_down),
        .key_ext   (key_ext),
        .press_cnt (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int bv_cnt = 0;
    int fe_cnt = 0;

    always @(negedge clk) begin
        if (byte_valid) bv_cnt++;
        if (frame_err)  fe_cnt++;
    end

    typedef struct {
        logic [7:0]       b;
        bit               bad;
        int               exp_bv;
        int               exp_fe;
        logic [7:0]       exp_data;
        logic [7:0]       exp_scan;
        logic             exp_down;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive the first nbits of a frame; parity is odd unless bad is set
    task automatic send_bits(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (8) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        @(negedge clk);
        bv_cnt = 0;
        fe_cnt = 0;
        send_bits(b, bad, 11);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_key(input string tag, input logic [7:0] sc, input logic dn,
                             input logic ex, input logic [CNT_W-1:0] cnt);
        chk({tag, ".scan_code"}, 32'(scan_code), 32'(sc));
        chk({tag, ".key_down"},  32'(key_down),  32'(dn));
        chk({tag, ".key_ext"},   32'(key_ext),   32'(ex));
        chk({tag, ".press_cnt"}, 32'(press_cnt), 32'(cnt));
    endtask

    logic exp_ext;
    logic exp_down_after;

    initial begin
        //            byte    bad   bv fe data    scan   dn cnt
        vecs[0] = '{8'h1C, 1'b0, 1, 0, 8'h1C, 8'h1C, 1'b1, 2'd1};
        vecs[1] = '{8'h1C, 1'b0, 1, 0, 8'h1C, 8'h1C, 1'b1, 2'd1};
        vecs[2] = '{8'h1C, 1'b0, 1, 0, 8'h1C, 8'h1C, 1'b1, 2'd1};
        vecs[3] = '{8'hF0, 1'b0, 1, 0, 8'hF0, 8'h1C, 1'b1, 2'd1};
        vecs[4] = '{8'h1C, 1'b0, 1, 0, 8'h1C, 8'h1C, 1'b0, 2'd1};
        vecs[5] = '{8'h1C, 1'b1, 0, 1, 8'h1C, 8'h1C, 1'b0, 2'd1};
        vecs[6] = '{8'h32, 1'b0, 1, 0, 8'h32, 8'h32, 1'b1, 2'd2};
        vecs[7] = '{8'hF0, 1'b0, 1, 0, 8'hF0, 8'h32, 1'b1, 2'd2};
        vecs[8] = '{8'h32, 1'b0, 1, 0, 8'h32, 8'h32, 1'b0, 2'd2};

        clrn     = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.byte_valid", 32'(byte_valid), 32'd0);
        chk("reset.byte_data",  32'(byte_data),  32'd0);
        chk("reset.frame_err",  32'(frame_err),  32'd0);
        check_key("reset", 8'h00, 1'b0, 1'b0, 2'd0);
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].b, vecs[i].bad);
            chk($sformatf("vec%0d.bv_pulses", i), 32'(bv_cnt), 32'(vecs[i].exp_bv));
            chk($sformatf("vec%0d.fe_pulses", i), 32'(fe_cnt), 32'(vecs[i].exp_fe));
            chk($sformatf("vec%0d.byte_data", i), 32'(byte_data), 32'(vecs[i].exp_data));
            check_key($sformatf("vec%0d", i), vecs[i].exp_scan, vecs[i].exp_down, 1'b0, vecs[i].exp_cnt);
        end

        // Partial frame abandoned by timeout, then a clean frame
        @(negedge clk);
        bv_cnt = 0;
        fe_cnt = 0;
        send_bits(8'h99, 1'b0, 5);
        repeat (TIMEOUT + 10) @(negedge clk);
        chk("timeout.fe_pulses", 32'(fe_cnt), 32'd0);
        chk("timeout.bv_pulses", 32'(bv_cnt), 32'd0);
        send_frame(8'h45, 1'b0);
        chk("after_to.bv_pulses", 32'(bv_cnt), 32'd1);
        chk("after_to.fe_pulses", 32'(fe_cnt), 32'd0);
        chk("after_to.byte_data", 32'(byte_data), 32'h45);
        check_key("after_to", 8'h45, 1'b1, 1'b0, 2'd3);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h45, 1'b0);
        check_key("rel45", 8'h45, 1'b0, 1'b0, 2'd3);

        // Reset in the middle of a frame
        send_frame(8'h21, 1'b0);
        send_bits(8'h5A, 1'b0, 5);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        chk("midrst.byte_data", 32'(byte_data), 32'd0);
        chk("midrst.byte_valid", 32'(byte_valid), 32'd0);
        chk("midrst.frame_err", 32'(frame_err), 32'd0);
        check_key("midrst", 8'h00, 1'b0, 1'b0, 2'd0);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        send_frame(8'h32, 1'b0);
        chk("post_rst.bv_pulses", 32'(bv_cnt), 32'd1);
        chk("post_rst.fe_pulses", 32'(fe_cnt), 32'd0);
        chk("post_rst.byte_data", 32'(byte_data), 32'h32);
        check_key("post_rst", 8'h32, 1'b1, 1'b0, 2'd1);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h32, 1'b0);

        // E0 prefix handling
`ifdef PS2_EXT_EN
        exp_ext        = 1'b1;
        exp_down_after = 1'b1;
`else
        exp_ext        = 1'b0;
        exp_down_after = 1'b0;
`endif
        send_frame(8'hE0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check_key("e0_1c", 8'h1C, 1'b1, exp_ext, 2'd2);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check_key("f0_1c", 8'h1C, exp_down_after, exp_ext, 2'd2);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check_key("e0_f0_1c", 8'h1C, 1'b0, exp_ext, 2'd2);

        // press_cnt wrap with a 2-bit counter
        @(negedge clk);
        clrn = 1'b0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'h1C, 1'b0);
            chk($sformatf("wrap%0d.press_cnt", i), 32'(press_cnt), 32'(i % 4));
            chk($sformatf("wrap%0d.key_down", i), 32'(key_down), 32'd1);
            send_frame(8'hF0, 1'b0);
            send_frame(8'h1C, 1'b0);
            chk($sformatf("wrap%0d.released", i), 32'(key_down), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
